stp_rx_ctrl: RTL and testbench
==============================

# stp_rx_ctrl

Frame controller for the serial-to-parallel shift register on the serial receive path. It gates the register's shift enable and counts bits into WORD_BITS-wide words. It captures each completed word from the register's parallel output into a holding register, and hands words downstream over a valid/ready handshake. One frame (WORDS_PER_FRAME words, a 512-bit block by default) is assembled per frame_start, ahead of the hashing core's input buffer.

## Interface
- WORD_BITS, 32, width of each word and of the shift register it controls (≥2)
- WORDS_PER_FRAME, 16, words per frame (≥1)
- clk  input  1  system clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in valid this cycle
- frame_start  input  1  qualifies bit_valid: this bit is bit 0 of word 0 of a new frame
- sr_shift_enable  output  1  to shift register shift_enable (combinational)
- sr_serial_in  output  1  to shift register serial_in (= bit_in, combinational)
- sr_parallel  input  WORD_BITS  from shift register parallel_out (configured MSB-first: first bit received ends in MSB)
- word_out  output  WORD_BITS  captured word
- word_idx  output  $clog2(WORDS_PER_FRAME) (min 1)  index of word_out within frame
- word_valid  output  1  word_out/word_idx valid
- word_ready  input  1  downstream accepts; transfer when word_valid & word_ready
- frame_done  output  1  one-cycle pulse, last word of frame first presented
- overrun  output  1  sticky: a completed word was dropped (see Configuration)
- err_clr  input  1  clears overrun

## Operation
- States: IDLE, RECV. Counters: bit_cnt (0..WORD_BITS-1), word_cnt (0..WORDS_PER_FRAME-1). Flag cap_pend.
- Accepted bit: bit_valid & (frame_start | state==RECV). sr_shift_enable = accepted bit; in IDLE, bits without frame_start are ignored (enable low).
- Accept with frame_start (any state): bit_cnt←1, word_cnt←0, state←RECV; a partial word/frame in progress is abandoned, no error. Already-captured/pending words are unaffected.
- Accept in RECV: bit_cnt+1; at bit_cnt==WORD_BITS-1: bit_cnt←0, cap_pend←1, capture index←word_cnt; if word_cnt==WORDS_PER_FRAME-1 then state←IDLE, word_cnt←0, last-word tag set; else word_cnt+1. Width-1 edge: WORD_BITS bits total, so frame_start bit counts as bit 0.
- Capture (cap_pend==1): if !word_valid or (word_valid & word_ready): word_out←sr_parallel, word_idx←capture index, word_valid←1, frame_done←last-word tag. Else: word dropped, overrun←1, holding register unchanged, frame_done not pulsed. cap_pend←0 either way.
- Capture in the same cycle as the next word's first bit is shifted is legal: sr_parallel sampled before the register updates.
- Transfer without capture: word_valid←0.
- err_clr clears overrun; a simultaneous new overrun wins (stays 1).
- rst: state IDLE, counters 0, cap_pend 0; word_out 0, word_idx 0, word_valid 0, frame_done 0, overrun 0. A pending word is discarded. The shift register is not cleared and needs no clearing: every word overwrites all WORD_BITS.

## Timing
- sr_shift_enable, sr_serial_in: zero latency from bit_valid/bit_in/frame_start.
- Last bit of a word presented in cycle t → shifted at end of t → captured at end of t+1 → word_valid (and frame_done for last word) high in cycle t+2.
- Back-to-back bits every cycle are supported indefinitely with word_ready held high: no bubbles, no overrun.
- frame_start accepted from cycle t+1 after a frame's last bit.
- frame_done high exactly one cycle; word_valid held until transfer.

## Configuration
- STP_RX_CTRL_OVERRUN_EN defined: overrun detection as above; overrun port live, err_clr honoured.
- Not defined: overrun tied 0, err_clr ignored; a capture into a full holding register overwrites word_out/word_idx (newest wins), word_valid stays 1, frame_done pulses normally.

## Test plan
(WORD_BITS=8, WORDS_PER_FRAME=2, macro defined unless noted)
- Reset: rst held 2 cycles mid-frame → all outputs 0, next 8 bits without frame_start produce no shift_enable and no word.
- Frame 0xA5,0x3C streamed every cycle, word_ready=1 → word_out 0xA5 idx 0 at t+2 after bit 7; 0x3C idx 1 with frame_done pulse; state back to IDLE.
- Gapped bit_valid (every 3rd cycle) → same words; shift_enable count = 16.
- word_ready=0 entire frame → word 0 held (0xA5, valid), word 1 dropped, overrun=1 stays until err_clr pulse; err_clr alone → 0.
- frame_start after 5 bits of word 1 → partial discarded, new frame's word 0 delivered with idx 0, overrun 0.
- Macro undefined, word_ready=0 → word_out becomes 0x3C idx 1, overrun stays 0.

Source files
------------

// File: rtl/stp_rx_ctrl_if.sv
// Downstream word handshake between stp_rx_ctrl and its consumer.
// The controller drives the word and its tags; the consumer drives word_ready.
interface stp_rx_ctrl_if #(
  parameter int WORD_BITS       = 32,
  parameter int WORDS_PER_FRAME = 16
);
  localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  logic [WORD_BITS-1:0] word_out;
  logic [IDX_W-1:0]     word_idx;
  logic                 word_valid;
  logic                 word_ready;
  logic                 frame_done;

  modport master (
    output word_out,
    output word_idx,
    output word_valid,
    output frame_done,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_idx,
    input  word_valid,
    input  frame_done,
    output word_ready
  );
endinterface

// File: rtl/stp_rx_ctrl.sv
// Frame controller for the serial-to-parallel receive shift register.
// Optional overrun detection is enabled by defining STP_RX_CTRL_OVERRUN_EN.
//
//   state | meaning
//   IDLE  | between frames; only a frame_start bit is accepted
//   RECV  | inside a frame; every valid bit is shifted and counted
module stp_rx_ctrl #(
  parameter int WORD_BITS       = 32,
  parameter int WORDS_PER_FRAME = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in_i,
  input  logic                 bit_valid_i,
  input  logic                 frame_start_i,
  output logic                 sr_shift_enable_o,
  output logic                 sr_serial_in_o,
  input  logic [WORD_BITS-1:0] sr_parallel_i,
  output logic                 overrun_o,
  input  logic                 err_clr_i,
  stp_rx_ctrl_if.master        word_if
);

  localparam int BIT_W = $clog2(WORD_BITS);
  localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t             state_q,    state_d;
  logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [IDX_W-1:0]   word_cnt_q, word_cnt_d;
  logic               cap_pend_q, cap_pend_d;
  logic [IDX_W-1:0]   cap_idx_q,  cap_idx_d;
  logic               cap_last_q, cap_last_d;

  logic [WORD_BITS-1:0] word_out_q,   word_out_d;
  logic [IDX_W-1:0]     word_idx_q,   word_idx_d;
  logic                 word_valid_q, word_valid_d;
  logic                 frame_done_q, frame_done_d;

  logic accept;
  logic transfer;

  assign accept            = bit_valid_i & (frame_start_i | (state_q == RECV));
  assign transfer          = word_valid_q & word_if.word_ready;
  assign sr_shift_enable_o = accept;
  assign sr_serial_in_o    = bit_in_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      cap_pend_q <= 1'b0;
      cap_idx_q  <= '0;
      cap_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      cap_pend_q <= cap_pend_d;
      cap_idx_q  <= cap_idx_d;
      cap_last_q <= cap_last_d;
    end
  end

  // The frame_start bit is bit 0 of word 0, so the count restarts at 1.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    cap_pend_d = 1'b0;
    cap_idx_d  = cap_idx_q;
    cap_last_d = cap_last_q;

    if (accept && frame_start_i) begin
      state_d    = RECV;
      bit_cnt_d  = BIT_W'(1);
      word_cnt_d = '0;
    end else if (accept) begin
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d  = '0;
        cap_pend_d = 1'b1;
        cap_idx_d  = word_cnt_q;
        if (word_cnt_q == WORD_LAST) begin
          state_d    = IDLE;
          word_cnt_d = '0;
          cap_last_d = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q + IDX_W'(1);
          cap_last_d = 1'b0;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_out_q   <= '0;
      word_idx_q   <= '0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      word_out_q   <= word_out_d;
      word_idx_q   <= word_idx_d;
      word_valid_q <= word_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef STP_RX_CTRL_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic drop;

  // A finished word meeting an untaken holding register is lost.
  assign drop = cap_pend_q & word_valid_q & ~word_if.word_ready;

  always_comb begin
    word_out_d   = word_out_q;
    word_idx_d   = word_idx_q;
    word_valid_d = word_valid_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q & ~err_clr_i;

    if (cap_pend_q && !drop) begin
      word_out_d   = sr_parallel_i;
      word_idx_d   = cap_idx_q;
      word_valid_d = 1'b1;
      frame_done_d = cap_last_q;
    end else if (drop) begin
      overrun_d = 1'b1;
    end else if (transfer) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_o = overrun_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr_i;

  // Without overrun detection the newest word always replaces the held one.
  always_comb begin
    word_out_d   = word_out_q;
    word_idx_d   = word_idx_q;
    word_valid_d = word_valid_q;
    frame_done_d = 1'b0;

    if (cap_pend_q) begin
      word_out_d   = sr_parallel_i;
      word_idx_d   = cap_idx_q;
      word_valid_d = 1'b1;
      frame_done_d = cap_last_q;
    end else if (transfer) begin
      word_valid_d = 1'b0;
    end
  end

  assign overrun_o = 1'b0;
`endif

  assign word_if.word_out   = word_out_q;
  assign word_if.word_idx   = word_idx_q;
  assign word_if.word_valid = word_valid_q;
  assign word_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_stp_rx_ctrl.sv
// Self-checking bench for stp_rx_ctrl (8-bit words, 2 words per frame) with an
// external MSB-first shift register and a frame-position reference model.
module tb_stp_rx_ctrl;
  localparam int WB    = 8;
  localparam int WPF   = 2;
  localparam int TOTAL = WB * WPF;

  logic clk = 1'b0;
  logic rst, bit_in, bit_valid, frame_start, word_ready, err_clr;
  logic [WB-1:0] sr_q = '0;
  logic sr_en, sr_ser, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stp_rx_ctrl_if #(.WORD_BITS(WB), .WORDS_PER_FRAME(WPF)) wif ();

  assign wif.word_ready = word_ready;

  stp_rx_ctrl #(.WORD_BITS(WB), .WORDS_PER_FRAME(WPF)) dut (
    .clk               (clk),
    .rst               (rst),
    .bit_in_i          (bit_in),
    .bit_valid_i       (bit_valid),
    .frame_start_i     (frame_start),
    .sr_shift_enable_o (sr_en),
    .sr_serial_in_o    (sr_ser),
    .sr_parallel_i     (sr_q),
    .overrun_o         (overrun),
    .err_clr_i         (err_clr),
    .word_if           (wif.master)
  );

  // External shift register: first bit received ends up in the MSB.
  always @(posedge clk) if (sr_en) sr_q <= {sr_q[WB-2:0], sr_ser};

  // Reference model: frame position as a plain bit count, words built arithmetically.
  int m_fpos = -1, m_acc = 0;
  int m_pv = 0, m_pw = 0, m_pi = 0, m_pl = 0;
  int m_hv = 0, m_hw = 0, m_hi = 0, m_fd = 0, m_ov = 0;
  int en_cnt = 0, fd_cnt = 0, xfer_cnt = 0;
  int xfer_q[$];

  always @(posedge clk) begin
    if (sr_en) en_cnt++;
    if (wif.word_valid && word_ready) begin
      xfer_cnt++;
      xfer_q.push_back(int'(wif.word_idx) * 256 + int'(wif.word_out));
    end
    if (rst) begin
      m_fpos = -1; m_acc = 0; m_pv = 0;
      m_hv = 0; m_hw = 0; m_hi = 0; m_fd = 0; m_ov = 0;
    end else begin
      m_fd = 0;
`ifdef STP_RX_CTRL_OVERRUN_EN
      if (err_clr) m_ov = 0;
`endif
      if (m_pv != 0) begin
        if (m_hv != 0 && !word_ready) begin
`ifdef STP_RX_CTRL_OVERRUN_EN
          m_ov = 1;
`else
          m_hw = m_pw; m_hi = m_pi; m_fd = m_pl;
`endif
        end else begin
          m_hv = 1; m_hw = m_pw; m_hi = m_pi; m_fd = m_pl;
        end
      end else if (m_hv != 0 && word_ready) begin
        m_hv = 0;
      end
      m_pv = 0;
      if (bit_valid && frame_start) begin
        m_fpos = 1;
        m_acc  = int'(bit_in);
      end else if (bit_valid && m_fpos >= 0) begin
        m_acc  = m_acc * 2 + int'(bit_in);
        m_fpos = m_fpos + 1;
        if (m_fpos % WB == 0) begin
          m_pv = 1; m_pw = m_acc % 256; m_pi = m_fpos / WB - 1;
          m_pl = (m_fpos == TOTAL) ? 1 : 0;
          m_acc = 0;
          if (m_pl != 0) m_fpos = -1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    #1;
    chk("sr_shift_enable", sr_en, (bit_valid && (frame_start || m_fpos >= 0)) ? 1 : 0);
    chk("sr_serial_in", sr_ser, bit_in);
    @(posedge clk);
    @(negedge clk);
    if (wif.frame_done) fd_cnt++;
    chk("word_valid", wif.word_valid, m_hv);
    chk("word_out", wif.word_out, m_hw);
    chk("word_idx", wif.word_idx, m_hi);
    chk("frame_done", wif.frame_done, m_fd);
    chk("overrun", overrun, m_ov);
  endtask

  task automatic send_bit(input logic b, input logic fs, input int gap);
    bit_valid = 1'b1; bit_in = b; frame_start = fs;
    tick();
    bit_valid = 1'b0; frame_start = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bit_in = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_word(input logic [WB-1:0] w, input logic first, input int gap);
    for (int i = WB - 1; i >= 0; i--) send_bit(w[i], first && (i == WB - 1), gap);
  endtask

  task automatic send_frame(input logic [WB-1:0] w0, input logic [WB-1:0] w1, input int gap);
    send_word(w0, 1'b1, gap);
    send_word(w1, 1'b0, gap);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [WB-1:0] w0;
    logic [WB-1:0] w1;
    int            gap;
    logic          ready;
    logic [WB-1:0] exp_word;
    logic          exp_idx;
    logic          exp_valid;
    logic          exp_ov;
    int            exp_fd;
  } vec_t;

  vec_t vecs[5];
  logic [WB-1:0] rw0, rw1;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{8'hA5, 8'h3C, 2, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1};
    vecs[3] = '{8'hFF, 8'h00, 1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1};
`ifdef STP_RX_CTRL_OVERRUN_EN
    vecs[2] = '{8'hA5, 8'h3C, 0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h01, 8'h80, 0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 0};
`else
    vecs[2] = '{8'hA5, 8'h3C, 0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1};
    vecs[4] = '{8'h01, 8'h80, 0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1};
`endif

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    word_ready = 1'b1; err_clr = 1'b0;
    do_reset(2);

    // Table-driven whole-frame vectors.
    for (int v = 0; v < 5; v++) begin
      do_reset(1);
      word_ready = vecs[v].ready;
      en_cnt = 0; fd_cnt = 0;
      send_frame(vecs[v].w0, vecs[v].w1, vecs[v].gap);
      repeat (4) tick();
      chk($sformatf("vec%0d word_out", v), wif.word_out, vecs[v].exp_word);
      chk($sformatf("vec%0d word_idx", v), wif.word_idx, vecs[v].exp_idx);
      chk($sformatf("vec%0d word_valid", v), wif.word_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d overrun", v), overrun, vecs[v].exp_ov);
      chk($sformatf("vec%0d frame_done_count", v), fd_cnt, vecs[v].exp_fd);
      chk($sformatf("vec%0d shift_count", v), en_cnt, TOTAL);
    end

    // Capture latency: word visible two cycles after its last bit.
    do_reset(1);
    word_ready = 1'b1;
    send_word(8'hA5, 1'b1, 0);
    chk("lat t+1 valid", wif.word_valid, 0);
    send_bit(1'b0, 1'b0, 0);
    chk("lat t+2 valid", wif.word_valid, 1);
    chk("lat t+2 word", wif.word_out, 8'hA5);
    chk("lat t+2 idx", wif.word_idx, 0);
    for (int i = WB - 2; i >= 0; i--) send_bit(1'(8'h3C >> i), 1'b0, 0);
    tick();
    chk("lat last word", wif.word_out, 8'h3C);
    chk("lat last idx", wif.word_idx, 1);
    chk("lat frame_done", wif.frame_done, 1);
    tick();
    chk("lat frame_done pulse", wif.frame_done, 0);
    bit_valid = 1'b1; bit_in = 1'b1;
    #1 chk("idle after frame enable", sr_en, 0);
    bit_valid = 1'b0;
    tick();

    // Overrun sticky, simultaneous set wins over err_clr, err_clr alone clears.
    do_reset(1);
    word_ready = 1'b0;
    send_frame(8'hA5, 8'h3C, 0);
    repeat (3) tick();
`ifdef STP_RX_CTRL_OVERRUN_EN
    chk("ovr sticky", overrun, 1);
`else
    chk("ovr disabled", overrun, 0);
`endif
    send_frame(8'h11, 8'h22, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
`ifdef STP_RX_CTRL_OVERRUN_EN
    chk("ovr set wins", overrun, 1);
`else
    chk("ovr disabled 2", overrun, 0);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("ovr cleared", overrun, 0);

    // Reset mid-frame with a held word, then frameless bits are ignored.
    send_word(8'h77, 1'b1, 0);
    send_bit(1'b1, 1'b1, 0);
    repeat (4) send_bit(1'b0, 1'b0, 0);
    do_reset(2);
    chk("rst word_valid", wif.word_valid, 0);
    chk("rst word_out", wif.word_out, 0);
    chk("rst word_idx", wif.word_idx, 0);
    chk("rst frame_done", wif.frame_done, 0);
    chk("rst overrun", overrun, 0);
    en_cnt = 0;
    word_ready = 1'b1;
    for (int i = 0; i < WB; i++) send_bit(1'($urandom), 1'b0, 0);
    repeat (3) tick();
    chk("rst no shift", en_cnt, 0);
    chk("rst no word", wif.word_valid, 0);

    // Partial frame abandoned by a new frame_start.
    do_reset(1);
    word_ready = 1'b1;
    xfer_q.delete();
    send_word(8'h11, 1'b1, 0);
    send_bit(1'b1, 1'b0, 0);
    repeat (4) send_bit(1'b0, 1'b0, 0);
    send_frame(8'h5A, 8'hC3, 0);
    repeat (4) tick();
    chk("abandon xfer count", xfer_q.size(), 3);
    if (xfer_q.size() == 3) begin
      chk("abandon w0", xfer_q[0], 32'h011);
      chk("abandon new w0", xfer_q[1], 32'h05A);
      chk("abandon new w1", xfer_q[2], 32'h1C3);
    end
    chk("abandon overrun", overrun, 0);

    // Back-to-back frames at full rate.
    do_reset(1);
    word_ready = 1'b1;
    xfer_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      rw0 = 8'($urandom); rw1 = 8'($urandom);
      send_frame(rw0, rw1, 0);
    end
    repeat (4) tick();
    chk("b2b xfer count", xfer_cnt, 6);
    chk("b2b overrun", overrun, 0);

    // Randomized traffic against the model.
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      bit_valid   = ($urandom_range(0, 9) < 6);
      bit_in      = 1'($urandom);
      frame_start = bit_valid && ($urandom_range(0, 23) == 0);
      word_ready  = ($urandom_range(0, 3) != 0);
      err_clr     = ($urandom_range(0, 29) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; err_clr = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
